// File: rtl/stim_phase_guard.sv
// rtl/stim_phase_guard.sv - dead-time, magnitude-freeze and fault guard for the stimulator H-bridge
module stim_phase_guard #(
  parameter int DEADTIME_CYC  = 4,
  parameter int MAX_PHASE_CYC = 160,
  parameter int MAG_W         = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN_ST,
  input  logic             CAT_ST,
  input  logic             ANO_ST,
  input  logic             DIS_ST,
  input  logic [MAG_W-1:0] MAG_ST,
  input  logic             fault_clr,
  output logic             DAC_EN,
  output logic [MAG_W-1:0] DAC_CODE,
  output logic             SW_CAT,
  output logic             SW_ANO,
  output logic             SW_DIS,
  output logic             FAULT,
  output logic [1:0]       fault_code,
  output logic             busy
);

  localparam int DW = $clog2(DEADTIME_CYC + 1);
  localparam int PW = $clog2(MAX_PHASE_CYC);
  localparam logic [DW-1:0] DLOAD = DW'(DEADTIME_CYC - 1);
  localparam logic [PW-1:0] PLAST = PW'(MAX_PHASE_CYC - 1);

  localparam logic [1:0] FC_OVERLAP = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;
  localparam logic [1:0] FC_NO_EN   = 2'b11;

  // One-hot encoding: bit 3/4/5 line up with request bit 0/1/2 (CAT/ANO/DIS)
  typedef enum logic [6:0] {
    ST_IDLE  = 7'b0000001,
    ST_ARMED = 7'b0000010,
    ST_DEAD  = 7'b0000100,
    ST_CAT   = 7'b0001000,
    ST_ANO   = 7'b0010000,
    ST_DIS   = 7'b0100000,
    ST_FAULT = 7'b1000000
  } state_e;

  // Registered copies of every input; the FSM never looks at the raw ports
  logic             r_en_q;
  logic [2:0]       r_req_q;   // {DIS, ANO, CAT}
  logic [MAG_W-1:0] r_mag_q;
  logic             r_clr_q;

  state_e           state_q, state_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [2:0]       tgt_q, tgt_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [1:0]       code_q, code_d;

  logic             req_none;
  logic             req_multi;
  logic             req_single;
  logic [2:0]       own_req;

  // Input sampling stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_q  <= 1'b0;
      r_req_q <= 3'b000;
      r_mag_q <= '0;
      r_clr_q <= 1'b0;
    end else begin
      r_en_q  <= EN_ST;
      r_req_q <= {DIS_ST, ANO_ST, CAT_ST};
      r_mag_q <= MAG_ST;
      r_clr_q <= fault_clr;
    end
  end

  // Request classification on the sampled inputs
  always_comb begin
    req_none   = (r_req_q == 3'b000);
    req_multi  = ((r_req_q & (r_req_q - 3'b001)) != 3'b000);
    req_single = !req_none && !req_multi;
    own_req    = state_q[5:3];
  end

  // State, counters, pending phase, frozen magnitude and fault cause
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
      pcnt_q  <= '0;
      tgt_q   <= 3'b000;
      mag_q   <= '0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
      tgt_q   <= tgt_d;
      mag_q   <= mag_d;
      code_q  <= code_d;
    end
  end

  // Next-state logic: fault traps first (overlap beats missing EN), then per-state sequencing
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    pcnt_d  = pcnt_q;
    tgt_d   = tgt_q;
    mag_d   = mag_q;
    code_d  = code_q;

    if (state_q != ST_FAULT && req_multi) begin
      state_d = ST_FAULT;
      code_d  = FC_OVERLAP;
    end else if (state_q != ST_FAULT && !req_none && !r_en_q) begin
      state_d = ST_FAULT;
      code_d  = FC_NO_EN;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // A request arriving together with EN does not arm; the generator must open EN first
          if (r_en_q && req_none) begin
            state_d = ST_ARMED;
            mag_d   = r_mag_q;
          end
        end
        ST_ARMED: begin
          if (req_single) begin
            state_d = ST_DEAD;
            dcnt_d  = DLOAD;
            tgt_d   = r_req_q;
          end else if (!r_en_q) begin
            state_d = ST_IDLE;
          end
        end
        ST_DEAD: begin
          if (req_none) begin
            state_d = ST_ARMED;
          end else if (r_req_q != tgt_q) begin
            dcnt_d = DLOAD;
            tgt_d  = r_req_q;
          end else if (dcnt_q == '0) begin
            pcnt_d = '0;
            case (tgt_q)
              3'b001:  state_d = ST_CAT;
              3'b010:  state_d = ST_ANO;
              default: state_d = ST_DIS;
            endcase
          end else begin
            dcnt_d = dcnt_q - DW'(1);
          end
        end
        ST_CAT, ST_ANO, ST_DIS: begin
          if (req_none) begin
            state_d = ST_ARMED;
          end else if (r_req_q != own_req) begin
            // Phase change: drop the current switch now, dead time runs in DEAD
            state_d = ST_DEAD;
            dcnt_d  = DLOAD;
            tgt_d   = r_req_q;
          end else if (pcnt_q == PLAST) begin
            state_d = ST_FAULT;
            code_d  = FC_TIMEOUT;
          end else begin
            pcnt_d = pcnt_q + PW'(1);
          end
        end
        ST_FAULT: begin
          if (r_clr_q && !r_en_q && req_none) begin
            state_d = ST_IDLE;
            code_d  = 2'b00;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode straight from the one-hot state register
  always_comb begin
    SW_CAT     = state_q[3];
    SW_ANO     = state_q[4];
    SW_DIS     = state_q[5];
    DAC_EN     = |state_q[5:1];
    DAC_CODE   = DAC_EN ? mag_q : '0;
    FAULT      = state_q[6];
    fault_code = state_q[6] ? code_q : 2'b00;
    busy       = !state_q[0];
  end

endmodule

// File: tb/tb_stim_phase_guard.sv
// tb/tb_stim_phase_guard.sv - directed self-checking bench for stim_phase_guard
module tb_stim_phase_guard;

  logic       clk = 1'b0;
  logic       rst;
  logic       EN_ST, CAT_ST, ANO_ST, DIS_ST, fault_clr;
  logic [4:0] MAG_ST;
  logic       DAC_EN, SW_CAT, SW_ANO, SW_DIS, FAULT, busy;
  logic [4:0] DAC_CODE;
  logic [1:0] fault_code;

  int checks   = 0;
  int failures = 0;

  // Per-scenario tallies gathered at every sample point
  int         cnt_cat, cnt_ano, cnt_dis, overlaps;
  int         off_run, min_gap, last_gap;
  bit         had_on;
  logic [2:0] prev_vec;

  stim_phase_guard #(
    .DEADTIME_CYC(4),
    .MAX_PHASE_CYC(160),
    .MAG_W(5)
  ) dut (
    .clk(clk), .rst(rst), .EN_ST(EN_ST), .CAT_ST(CAT_ST), .ANO_ST(ANO_ST),
    .DIS_ST(DIS_ST), .MAG_ST(MAG_ST), .fault_clr(fault_clr), .DAC_EN(DAC_EN),
    .DAC_CODE(DAC_CODE), .SW_CAT(SW_CAT), .SW_ANO(SW_ANO), .SW_DIS(SW_DIS),
    .FAULT(FAULT), .fault_code(fault_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_tally();
    cnt_cat  = 0; cnt_ano = 0; cnt_dis = 0; overlaps = 0;
    off_run  = 0; min_gap = 1000; last_gap = -1; had_on = 1'b0;
    prev_vec = 3'b000;
  endtask

  task automatic sample();
    logic [2:0] v;
    v = {SW_DIS, SW_ANO, SW_CAT};
    if (SW_CAT) cnt_cat++;
    if (SW_ANO) cnt_ano++;
    if (SW_DIS) cnt_dis++;
    if ((v & (v - 3'b001)) != 3'b000) overlaps++;
    if (v != 3'b000) begin
      if (prev_vec != 3'b000 && prev_vec != v) min_gap = 0;
      if (had_on && off_run > 0) begin
        last_gap = off_run;
        if (off_run < min_gap) min_gap = off_run;
      end
      off_run = 0;
      had_on  = 1'b1;
    end else if (had_on) begin
      off_run++;
    end
    prev_vec = v;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      sample();
    end
  endtask

  initial begin
    rst = 1'b1; EN_ST = 1'b0; CAT_ST = 1'b0; ANO_ST = 1'b0; DIS_ST = 1'b0;
    MAG_ST = 5'd0; fault_clr = 1'b0;
    clr_tally();
    run(3);
    chk("reset_sw", int'({SW_DIS, SW_ANO, SW_CAT}), 0);
    chk("reset_dac_en", int'(DAC_EN), 0);
    chk("reset_dac_code", int'(DAC_CODE), 0);
    chk("reset_fault", int'({FAULT, fault_code}), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    run(2);
    chk("idle_busy", int'(busy), 0);

    // Nominal sequence: CAT 150, gap 10, ANO 150, DIS 5 directly after ANO
    MAG_ST = 5'd31; EN_ST = 1'b1;
    run(3);
    chk("armed_busy", int'(busy), 1);
    chk("armed_dac_en", int'(DAC_EN), 1);
    chk("armed_dac_code", int'(DAC_CODE), 31);
    clr_tally();
    CAT_ST = 1'b1; run(150);
    CAT_ST = 1'b0; run(10);
    ANO_ST = 1'b1; run(150);
    ANO_ST = 1'b0; DIS_ST = 1'b1; run(5);
    DIS_ST = 1'b0; run(10);
    chk("nom_cat_on", cnt_cat, 146);
    chk("nom_ano_on", cnt_ano, 146);
    chk("nom_dis_on", cnt_dis, 1);
    chk("nom_overlap", overlaps, 0);
    chk("nom_min_gap", min_gap, 4);
    chk("ano_dis_gap", last_gap, 4);
    chk("nom_dac_code", int'(DAC_CODE), 31);
    EN_ST = 1'b0; run(5);
    chk("nom_busy_end", int'(busy), 0);
    chk("nom_dac_en_end", int'(DAC_EN), 0);

    // Overlap fault and clear rules
    EN_ST = 1'b1; run(3);
    clr_tally();
    CAT_ST = 1'b1; ANO_ST = 1'b1; run(2);
    chk("ovl_fault", int'(FAULT), 1);
    chk("ovl_code", int'(fault_code), 1);
    chk("ovl_gates", int'({SW_DIS, SW_ANO, SW_CAT, DAC_EN}), 0);
    chk("ovl_dac_code", int'(DAC_CODE), 0);
    chk("ovl_no_sw", cnt_cat + cnt_ano + cnt_dis, 0);
    CAT_ST = 1'b0; ANO_ST = 1'b0; fault_clr = 1'b1; run(4);
    chk("clr_en_high_fault", int'(FAULT), 1);
    chk("clr_en_high_code", int'(fault_code), 1);
    EN_ST = 1'b0; run(3);
    chk("clr_en_low_fault", int'(FAULT), 0);
    chk("clr_en_low_busy", int'(busy), 0);
    fault_clr = 1'b0; run(2);

    // Request without EN from IDLE
    CAT_ST = 1'b1; run(2);
    chk("noen_idle_fault", int'(FAULT), 1);
    chk("noen_idle_code", int'(fault_code), 3);
    CAT_ST = 1'b0; fault_clr = 1'b1; run(3);
    chk("noen_idle_clr", int'(FAULT), 0);
    fault_clr = 1'b0; run(2);

    // EN dropped while a phase is on
    EN_ST = 1'b1; run(3);
    CAT_ST = 1'b1; run(10);
    chk("midphase_on", int'(SW_CAT), 1);
    EN_ST = 1'b0; run(2);
    chk("midphase_fault", int'(FAULT), 1);
    chk("midphase_code", int'(fault_code), 3);
    chk("midphase_sw_off", int'(SW_CAT), 0);
    CAT_ST = 1'b0; fault_clr = 1'b1; run(3);
    chk("midphase_clr", int'(FAULT), 0);
    fault_clr = 1'b0; run(2);

    // Phase timeout
    EN_ST = 1'b1; run(3);
    clr_tally();
    CAT_ST = 1'b1; run(200);
    chk("tmo_cat_on", cnt_cat, 160);
    chk("tmo_fault", int'(FAULT), 1);
    chk("tmo_code", int'(fault_code), 2);
    chk("tmo_sw_off", int'(SW_CAT), 0);
    CAT_ST = 1'b0; EN_ST = 1'b0; fault_clr = 1'b1; run(3);
    chk("tmo_clr", int'(FAULT), 0);
    fault_clr = 1'b0; run(2);

    // Magnitude freeze
    MAG_ST = 5'd31; EN_ST = 1'b1; run(3);
    CAT_ST = 1'b1; run(20);
    chk("mag_pulse1", int'(DAC_CODE), 31);
    MAG_ST = 5'd7; run(20);
    chk("mag_frozen_sw", int'(SW_CAT), 1);
    chk("mag_frozen", int'(DAC_CODE), 31);
    CAT_ST = 1'b0; run(10);
    chk("mag_armed_frozen", int'(DAC_CODE), 31);
    EN_ST = 1'b0; run(4);
    chk("mag_idle_zero", int'(DAC_CODE), 0);
    EN_ST = 1'b1; run(3);
    CAT_ST = 1'b1; run(10);
    chk("mag_pulse2_sw", int'(SW_CAT), 1);
    chk("mag_pulse2", int'(DAC_CODE), 7);
    CAT_ST = 1'b0; run(5);
    EN_ST = 1'b0; run(4);

    // Reset in the middle of a pulse, then recovery
    MAG_ST = 5'd12; EN_ST = 1'b1; run(3);
    CAT_ST = 1'b1; run(10);
    chk("rst_pre_on", int'(SW_CAT), 1);
    rst = 1'b1; CAT_ST = 1'b0; run(1);
    chk("rst_mid_sw", int'({SW_DIS, SW_ANO, SW_CAT}), 0);
    chk("rst_mid_dac", int'({DAC_EN, DAC_CODE}), 0);
    chk("rst_mid_busy", int'({busy, FAULT}), 0);
    rst = 1'b0; run(3);
    chk("rst_rearm_busy", int'(busy), 1);
    chk("rst_rearm_code", int'(DAC_CODE), 12);
    clr_tally();
    CAT_ST = 1'b1; run(20);
    CAT_ST = 1'b0; run(5);
    chk("rst_pulse_on", cnt_cat, 16);
    EN_ST = 1'b0; run(4);
    chk("rst_end_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
